// File: rtl/param_stack_if.sv
// Stack port bundle: control strobes and write data from the master, stack state back from the slave.
interface param_stack_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  CLR;
    logic                  PUSH;
    logic                  POP;
    logic [DATA_WIDTH-1:0] Data_in;
    logic [DATA_WIDTH-1:0] Data_out;
    logic [ADDR_WIDTH-1:0] SP;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  EMPTY;
    logic                  FULL;
    logic                  OVF;
    logic                  UNF;

    modport master (
        output CLR, PUSH, POP, Data_in,
        input  Data_out, SP, COUNT, EMPTY, FULL, OVF, UNF
    );

    modport slave (
        input  CLR, PUSH, POP, Data_in,
        output Data_out, SP, COUNT, EMPTY, FULL, OVF, UNF
    );
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO stack with reject/wrap overflow policy, replace on push+pop and flush.
// Sticky OVF/UNF flags are built only when STACK_ERR_FLAGS_EN is defined.
module param_stack #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter bit WRAP_ON_FULL = 1'b0
) (
    input logic         CLK,
    input logic         RST,
    param_stack_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] SP_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] sp_q, sp_d, sp_inc, sp_dec, waddr;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  we, empty, full;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign sp_inc = sp_q + SP_ONE;
    assign sp_dec = sp_q - SP_ONE;

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        dout_d  = dout_q;
        we      = 1'b0;
        waddr   = sp_q;
        if (bus.CLR) begin
            sp_d    = '1;
            count_d = '0;
            dout_d  = '0;
        end else if (bus.PUSH && bus.POP && !empty) begin
            // Replace the top entry in place; pointer and occupancy hold.
            we     = 1'b1;
            dout_d = bus.Data_in;
        end else if (bus.PUSH) begin
            if (!full) begin
                sp_d    = sp_inc;
                count_d = count_q + CNT_ONE;
                we      = 1'b1;
                waddr   = sp_inc;
                dout_d  = bus.Data_in;
            end else if (WRAP_ON_FULL) begin
                // Advancing the pointer when full lands on the oldest entry.
                sp_d   = sp_inc;
                we     = 1'b1;
                waddr  = sp_inc;
                dout_d = bus.Data_in;
            end
        end else if (bus.POP && !empty) begin
            sp_d    = sp_dec;
            count_d = count_q - CNT_ONE;
            dout_d  = (count_q == CNT_ONE) ? '0 : mem[sp_dec];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sp_q    <= '1;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && we) begin
            mem[waddr] <= bus.Data_in;
        end
    end

`ifdef STACK_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.CLR) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (bus.PUSH && full && !bus.POP) ovf_d = 1'b1;
            if (bus.POP && empty && !bus.PUSH) unf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.OVF = ovf_q;
    assign bus.UNF = unf_q;
`else
    assign bus.OVF = 1'b0;
    assign bus.UNF = 1'b0;
`endif

    assign bus.Data_out = dout_q;
    assign bus.SP       = sp_q;
    assign bus.COUNT    = count_q;
    assign bus.EMPTY    = empty;
    assign bus.FULL     = full;
endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack: the successor to the single-width, fixed-depth stack used for call/return and save/restore storage in the pipelined MIPS datapath. It adds configurable width and depth, a selectable overflow policy (reject or circular overwrite), push+pop in the same cycle as a replace, a synchronous flush, an occupancy count, and optional sticky error flags. All pointer and data updates occur on the rising edge of a single clock.

## Interface
- DATA_WIDTH, 32, entry width in bits
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
- WRAP_ON_FULL, 0, overflow policy: 0 = reject push when full; 1 = overwrite oldest entry
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  synchronous active-low reset
- CLR  input  1  synchronous flush, active-high
- PUSH  input  1  push Data_in
- POP  input  1  pop top entry
- Data_in  input  DATA_WIDTH  data to push
- Data_out  output  DATA_WIDTH  registered top-of-stack; 0 when empty
- SP  output  ADDR_WIDTH  index of the top entry; all-ones after reset
- COUNT  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
- EMPTY  output  1  COUNT == 0
- FULL  output  1  COUNT == DEPTH
- OVF  output  1  sticky overflow flag
- UNF  output  1  sticky underflow flag

## Operation
- Priority: RST low > CLR > PUSH/POP.
- RST low or CLR high: SP = all-ones, COUNT = 0, Data_out = 0, OVF = UNF = 0. The memory array is not reset.
- Push only, not full: SP+1 (modulo DEPTH), mem[SP+1] = Data_in, COUNT+1, Data_out = Data_in.
- Push only, full, WRAP_ON_FULL=0: push is dropped. SP, COUNT, Data_out and memory are unchanged. OVF is set.
- Push only, full, WRAP_ON_FULL=1: SP+1 (modulo DEPTH), overwriting the oldest entry. COUNT stays DEPTH, Data_out = Data_in, OVF is set.
- Pop only, COUNT ≥ 2: SP−1, COUNT−1, Data_out = mem[SP−1], read combinationally from the array in the same cycle.
- Pop only, COUNT = 1: SP−1, COUNT = 0, Data_out = 0.
- Pop only, empty: no state change, Data_out stays 0, UNF is set.
- Push and pop, not empty (full included): replace. mem[SP] = Data_in, Data_out = Data_in, SP and COUNT unchanged, no flag set.
- Push and pop, empty: treated as push only. COUNT becomes 1, UNF is not set.
- Pointer arithmetic wraps modulo DEPTH. COUNT saturates at DEPTH and never underflows.

## Timing
- Latency is one cycle: an operation sampled at edge N is reflected on SP, COUNT, Data_out and the flags after edge N.
- EMPTY and FULL are decoded combinationally from the COUNT register, so they have no extra latency.
- There is no handshake. PUSH and POP are single-cycle strobes and may be held high for back-to-back operations every cycle.
- Reset mid-operation: RST low at any edge overrides a concurrent PUSH/POP. The following push writes index 0.
- Data_in is sampled only on edges where a write occurs.

## Configuration
- STACK_ERR_FLAGS_EN defined: OVF and UNF are sticky registers, set as described under Operation and cleared only by RST or CLR.
- STACK_ERR_FLAGS_EN undefined: OVF and UNF are tied to 0 and the flag logic is not synthesised. All other behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=32 and ADDR_WIDTH=2 (DEPTH=4), with STACK_ERR_FLAGS_EN defined.
- Reset: hold RST low for one edge → SP=2'b11, COUNT=0, EMPTY=1, FULL=0, Data_out=0, OVF=UNF=0.
- Fill and drain: push 0xA, 0xB, 0xC, 0xD → COUNT=4, FULL=1, Data_out=0xD, SP=3. Then pop four times → Data_out sequence 0xC, 0xB, 0xA, 0, with EMPTY=1 after the last pop.
- Overflow policy:
  - WRAP_ON_FULL=0: with the stack full of 0xA..0xD, push 0xE → COUNT=4, Data_out=0xD, OVF=1.
  - WRAP_ON_FULL=1: same stimulus → Data_out=0xE, SP=0, OVF=1. Four pops then return 0xD, 0xC, 0xB, 0 (0xA is lost).
- Replace: with the stack holding 0xA, 0xB, assert PUSH+POP with Data_in=0x55 → COUNT=2, Data_out=0x55; one pop → Data_out=0xA. On an empty stack, PUSH+POP with 0x5 → COUNT=1, Data_out=0x5, UNF=0.
- Underflow and flush: pop on an empty stack → COUNT=0, Data_out=0, UNF=1. Then pulse CLR for one cycle → UNF=0, SP=2'b11.
- Reset mid-stream: with COUNT=3, drive RST low concurrently with PUSH → COUNT=0 and Data_out=0 on the next cycle. A subsequent push of 0x7 → SP=0, Data_out=0x7.
